// File: rtl/cpu_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared encodings for the CPU run controller: run modes, controller states
// and the helper that maps the raw 2-bit mode input onto a run mode.
// ----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        RUN_COUNT = 2'd0,  // run a fixed number of cycles
        RUN_HALT  = 2'd1,  // run until OUT is stable, bounded by the limit
        RUN_STEP  = 2'd2   // one enabled CPU cycle per step request
    } run_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_RUN        = 3'd2,
        ST_STEP       = 3'd3,
        ST_DONE       = 3'd4
    } run_state_e;

    // Encoding 3 is unused and behaves like a fixed-count run.
    function automatic run_mode_e decode_mode(input logic [MODE_W-1:0] raw);
        case (raw)
            2'd1:    return RUN_HALT;
            2'd2:    return RUN_STEP;
            default: return RUN_COUNT;
        endcase
    endfunction

endpackage : cpu_run_ctrl_pkg

// File: rtl/cpu_run_ctrl_halt_detect.sv
// ----------------------------------------------------------------------------
// cpu_halt_detect
// Decides that the CPU has halted when its OUT bus has compared equal to the
// previous sample on HALT_STABLE consecutive sampled cycles.
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   clr_i        forget the previous sample and zero the stable count
//   sample_en_i  compare and capture din_i this cycle
//   din_i        CPU OUT bus
//   halted_o     this cycle's compare completes the stable run (combinational)
// ----------------------------------------------------------------------------
module cpu_halt_detect #(
    parameter int DATA_W      = 32,
    parameter int HALT_STABLE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              halted_o
);

    localparam int                STAB_W   = $clog2(HALT_STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(HALT_STABLE);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    logic              equal;

    // No valid previous sample means the first sampled cycle never counts as equal.
    assign equal = prev_vld_q && (din_i == prev_q);

    // The cycle whose equal compare would lift the count to HALT_STABLE is the
    // halt cycle, so the controller can leave RUN right after it.
    assign halted_o = sample_en_i && !clr_i && equal && (stable_q >= STAB_MAX - STAB_W'(1));

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        stable_d   = stable_q;
        if (clr_i) begin
            prev_d     = '0;
            prev_vld_d = 1'b0;
            stable_d   = '0;
        end else if (sample_en_i) begin
            prev_d     = din_i;
            prev_vld_d = 1'b1;
            if (!equal) begin
                stable_d = '0;
            end else if (stable_q != STAB_MAX) begin
                stable_d = stable_q + STAB_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            stable_q   <= '0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            stable_q   <= stable_d;
        end
    end

endmodule : cpu_halt_detect

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for the pipelined CPU. After start it holds the CPU in reset
// for RESET_HOLD enabled cycles, then runs it in one of three modes: fixed
// cycle count, run-to-halt with a cycle limit, or single step. Reports the
// enabled run-cycle count, done/timeout and the last sampled CPU OUT value.
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   start_i       begin a run (accepted in IDLE or DONE)
//   abort_i       return to IDLE from any state
//   mode_i        0 count, 1 halt-detect, 2 single-step, 3 as 0
//   max_cycles_i  run-cycle limit
//   step_i        single-step request, one grant per high cycle
//   cpu_out_i     CPU OUT bus
//   cpu_rst_o     active-high synchronous reset to the CPU
//   cpu_ce_o      CPU clock enable
//   busy_o        run in progress
//   done_o        run finished (level)
//   timeout_o     halt-detect run ended on the limit
//   cycles_o      enabled run cycles since start
//   result_o      CPU OUT on the last enabled run cycle
// ----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int RESET_HOLD  = 2,
    parameter int HALT_STABLE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  max_cycles_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] cpu_out_i,
    output logic              cpu_rst_o,
    output logic              cpu_ce_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int                HOLD_W    = $clog2(RESET_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    run_state_e        state_q, state_d;
    run_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic              grant_q, grant_d;

    logic              halt_clr;
    logic              halt_sample;
    logic              halted;
    logic [CNT_W-1:0]  cycles_inc;
    logic              at_limit;

    // cycles_q < max_q whenever it is incremented, so this never wraps.
    assign cycles_inc  = cycles_q + CNT_W'(1);
    assign at_limit    = (cycles_inc == max_q);
    assign halt_sample = (state_q == ST_RUN);

    cpu_halt_detect #(
        .DATA_W      (DATA_W),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt_detect (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (halt_clr),
        .sample_en_i (halt_sample),
        .din_i       (cpu_out_i),
        .halted_o    (halted)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        max_d     = max_q;
        cycles_d  = cycles_q;
        result_d  = result_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;
        grant_d   = 1'b0;
        halt_clr  = 1'b0;

        if (abort_i) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d   = ST_RESET_HOLD;
                        mode_d    = decode_mode(mode_i);
                        max_d     = max_cycles_i;
                        cycles_d  = '0;
                        result_d  = '0;
                        hold_d    = '0;
                        timeout_d = 1'b0;
                        halt_clr  = 1'b1;
                    end
                end
                ST_RESET_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        if (max_q == '0) begin
                            state_d   = ST_DONE;
                            timeout_d = (mode_q == RUN_HALT);
                        end else if (mode_q == RUN_STEP) begin
                            state_d = ST_STEP;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cycles_d = cycles_inc;
                    result_d = cpu_out_i;
                    // Halt is checked first so a halt on the limit cycle is not a timeout.
                    if ((mode_q == RUN_HALT) && halted) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b0;
                    end else if (at_limit) begin
                        state_d   = ST_DONE;
                        timeout_d = (mode_q == RUN_HALT);
                    end
                end
                ST_STEP: begin
                    if (grant_q) begin
                        cycles_d = cycles_inc;
                        result_d = cpu_out_i;
                        if (at_limit) begin
                            state_d = ST_DONE;
                        end
                    end
                    // A step request is registered into a one-cycle grant so cpu_ce
                    // stays a flop output; requests are dropped once the run ends.
                    grant_d = step_i && (state_d == ST_STEP);
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            mode_q    <= RUN_COUNT;
            max_q     <= '0;
            cycles_q  <= '0;
            result_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            max_q     <= max_d;
            cycles_q  <= cycles_d;
            result_q  <= result_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            grant_q   <= grant_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        cpu_rst_o = 1'b0;
        cpu_ce_o  = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_rst_o = 1'b1;
            end
            ST_RESET_HOLD: begin
                cpu_rst_o = 1'b1;
                cpu_ce_o  = 1'b1;
                busy_o    = 1'b1;
            end
            ST_RUN: begin
                cpu_ce_o = 1'b1;
                busy_o   = 1'b1;
            end
            ST_STEP: begin
                cpu_ce_o = grant_q;
                busy_o   = 1'b1;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                cpu_rst_o = 1'b1;
            end
        endcase
    end

    assign timeout_o = timeout_q;
    assign cycles_o  = cycles_q;
    assign result_o  = result_q;

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. A small stub CPU advances a counter on each
// enabled, non-reset cycle and presents a pattern-selected value on OUT.
// Outputs are sampled and inputs driven on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 16;
    localparam int RESET_HOLD  = 2;
    localparam int HALT_STABLE = 4;
    localparam int RUN_BOUND   = 2000;
    localparam int NV          = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, step;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  max_cycles;
    logic [DATA_W-1:0] cpu_out;
    logic              cpu_rst, cpu_ce, busy, done, timeout;
    logic [CNT_W-1:0]  cycles;
    logic [DATA_W-1:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .RESET_HOLD  (RESET_HOLD),
        .HALT_STABLE (HALT_STABLE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .mode_i       (mode),
        .max_cycles_i (max_cycles),
        .step_i       (step),
        .cpu_out_i    (cpu_out),
        .cpu_rst_o    (cpu_rst),
        .cpu_ce_o     (cpu_ce),
        .busy_o       (busy),
        .done_o       (done),
        .timeout_o    (timeout),
        .cycles_o     (cycles),
        .result_o     (result)
    );

    // Stub CPU: pc counts enabled run cycles, cleared by an enabled reset cycle.
    // pat 0: changes every cycle; pat 1: varies, then 0x2A from run cycle 10;
    // pat 2: constant 0x55.
    logic [15:0] cpu_pc;
    int          pat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cpu_pc <= 16'd0;
        else if (cpu_ce) cpu_pc <= cpu_rst ? 16'd0 : cpu_pc + 16'd1;
    end

    always_comb begin
        cpu_out = {16'hC0DE, cpu_pc};
        case (pat)
            1:       cpu_out = (cpu_pc >= 16'd9) ? 32'h2A : (32'd100 + {16'd0, cpu_pc});
            2:       cpu_out = 32'h55;
            default: cpu_out = {16'hC0DE, cpu_pc};
        endcase
    end

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] max;
        int          pat;
        int          exp_len;     // falling edges from start accepted to done seen
        int          exp_ce;      // enabled cycles over that span
        logic [15:0] exp_cycles;
        logic        exp_timeout;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called on the falling edge after start was accepted; returns on the
    // falling edge where done is first seen (or when the bound runs out).
    task automatic run_to_done(output int len, output int ce_cnt, output int rst_cnt);
        len = 0; ce_cnt = 0; rst_cnt = 0;
        while (!done && len < RUN_BOUND) begin
            if (cpu_ce)  ce_cnt++;
            if (cpu_rst) rst_cnt++;
            @(negedge clk);
            len++;
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [15:0] mx, input int p);
        pat = p; mode = m; max_cycles = mx; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int len, ce_cnt, rst_cnt, n;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; step = 1'b0;
        mode = 2'd0; max_cycles = '0; pat = 0;

        //            mode  max   pat len  ce   cycles to    result
        vecs[0] = '{2'd0, 16'd467, 0, 469, 469, 16'd467, 1'b0, 32'hC0DE01D2};
        vecs[1] = '{2'd1, 16'd100, 1, 16,  16,  16'd14,  1'b0, 32'h2A};
        vecs[2] = '{2'd1, 16'd100, 0, 102, 102, 16'd100, 1'b1, 32'hC0DE0063};
        vecs[3] = '{2'd1, 16'd14,  1, 16,  16,  16'd14,  1'b0, 32'h2A};
        vecs[4] = '{2'd1, 16'd13,  1, 15,  15,  16'd13,  1'b1, 32'h2A};
        vecs[5] = '{2'd1, 16'd100, 2, 7,   7,   16'd5,   1'b0, 32'h55};
        vecs[6] = '{2'd3, 16'd7,   2, 9,   9,   16'd7,   1'b0, 32'h55};
        vecs[7] = '{2'd0, 16'd0,   0, 2,   2,   16'd0,   1'b0, 32'h0};
        vecs[8] = '{2'd0, 16'd1,   0, 3,   3,   16'd1,   1'b0, 32'hC0DE0000};
        vecs[9] = '{2'd1, 16'd0,   0, 2,   2,   16'd0,   1'b1, 32'h0};

        #12;
        check("reset cpu_rst", cpu_rst, 1'b1);
        check("reset cpu_ce",  cpu_ce,  1'b0);
        check("reset busy",    busy,    1'b0);
        check("reset done",    done,    1'b0);
        check("reset timeout", timeout, 1'b0);
        check("reset cycles",  cycles,  '0);
        check("reset result",  result,  '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            start_run(vecs[i].mode, vecs[i].max, vecs[i].pat);
            check($sformatf("v%0d hold cpu_rst", i), cpu_rst, 1'b1);
            check($sformatf("v%0d hold busy", i),    busy,    1'b1);
            check($sformatf("v%0d hold done", i),    done,    1'b0);
            run_to_done(len, ce_cnt, rst_cnt);
            check($sformatf("v%0d done", i),      done,    1'b1);
            check($sformatf("v%0d busy end", i),  busy,    1'b0);
            check($sformatf("v%0d cpu_ce end", i), cpu_ce, 1'b0);
            check($sformatf("v%0d length", i),    len,     vecs[i].exp_len);
            check($sformatf("v%0d ce count", i),  ce_cnt,  vecs[i].exp_ce);
            check($sformatf("v%0d rst count", i), rst_cnt, RESET_HOLD);
            check($sformatf("v%0d cycles", i),    cycles,  vecs[i].exp_cycles);
            check($sformatf("v%0d timeout", i),   timeout, vecs[i].exp_timeout);
            check($sformatf("v%0d result", i),    result,  vecs[i].exp_result);
        end

        // Abort from DONE with timeout set clears done/timeout.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort done: done",    done,    1'b0);
        check("abort done: timeout", timeout, 1'b0);
        check("abort done: cpu_rst", cpu_rst, 1'b1);

        // Single step: grants follow step-high cycles one for one.
        start_run(2'd2, 16'd3, 0);
        @(negedge clk);
        @(negedge clk);
        check("step entry busy",    busy,    1'b1);
        check("step entry cpu_rst", cpu_rst, 1'b0);
        check("step entry cpu_ce",  cpu_ce,  1'b0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step1 cpu_ce", cpu_ce, 1'b1);
        check("step1 cycles", cycles, 16'd0);
        @(negedge clk);
        check("gap cpu_ce",   cpu_ce, 1'b0);
        check("step1 count",  cycles, 16'd1);
        step = 1'b1;
        @(negedge clk);
        check("step2 cpu_ce", cpu_ce, 1'b1);
        check("step2 cycles", cycles, 16'd1);
        @(negedge clk);
        step = 1'b0;
        check("step3 cpu_ce", cpu_ce, 1'b1);
        check("step2 count",  cycles, 16'd2);
        @(negedge clk);
        check("step done",    done,   1'b1);
        check("step3 count",  cycles, 16'd3);
        check("step ce off",  cpu_ce, 1'b0);
        check("step result",  result, 32'hC0DE0002);

        // Abort mid-run once 50 run cycles have been counted.
        start_run(2'd0, 16'd200, 0);
        n = 0;
        while (cycles != 16'd50 && n < RUN_BOUND) begin
            @(negedge clk);
            n++;
        end
        check("abort reach 50", cycles, 16'd50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort cpu_rst", cpu_rst, 1'b1);
        check("abort cpu_ce",  cpu_ce,  1'b0);
        check("abort busy",    busy,    1'b0);
        check("abort done",    done,    1'b0);
        check("abort cycles",  cycles,  16'd50);
        @(negedge clk);
        check("abort idle cycles hold", cycles, 16'd50);

        // Reset low mid-run takes effect without a clock edge.
        start_run(2'd0, 16'd200, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst cpu_rst", cpu_rst, 1'b1);
        check("midrst cpu_ce",  cpu_ce,  1'b0);
        check("midrst busy",    busy,    1'b0);
        check("midrst cycles",  cycles,  '0);
        check("midrst result",  result,  '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // start while running is ignored; start in DONE begins a new run.
        start_run(2'd0, 16'd20, 0);
        repeat (5) @(negedge clk);
        start_run(2'd1, 16'd3, 2);
        run_to_done(len, ce_cnt, rst_cnt);
        check("ignored start cycles",  cycles,  16'd20);
        check("ignored start timeout", timeout, 1'b0);
        check("ignored start length",  len + 6, 22);
        start_run(2'd0, 16'd3, 0);
        check("restart busy",    busy,    1'b1);
        check("restart done",    done,    1'b0);
        check("restart cycles",  cycles,  '0);
        check("restart cpu_rst", cpu_rst, 1'b1);
        run_to_done(len, ce_cnt, rst_cnt);
        check("restart length", len,    5);
        check("restart end",    cycles, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cpu_run_ctrl
